// File: rtl/hs_pkg.sv
// Shared definitions for the HPS ioctl initiator (hs_ioctl_player).
// Holds the player FSM state encoding, the ioctl index values used by the
// hiscore block, and the transfer-length clamp helper.
package hs_pkg;

  // Player FSM states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE      = 3'd1,
    DL_FETCH = 3'd2,
    DL_WR    = 3'd3,
    DL_GAP   = 3'd4,
    UL_HOLD  = 3'd5,
    UL_CAP   = 3'd6,
    POST     = 3'd7
  } hs_state_e;

  // ioctl_index values understood by the hiscore block.
  localparam logic [7:0] HS_CONFIGINDEX = 8'd3;
  localparam logic [7:0] HS_DUMPINDEX   = 8'd4;

  // Limit a requested byte count to what the local buffer can hold.
  function automatic logic [24:0] hs_clamp_len(input logic [24:0] req_len,
                                               input logic [24:0] max_len);
    logic [24:0] res;
    if (req_len > max_len) begin
      res = max_len;
    end else begin
      res = req_len;
    end
    return res;
  endfunction

endpackage

// File: rtl/hs_ioctl_player.sv
// Initiator side of the HPS ioctl byte stream.
// Replays the local buffer as an ioctl download, or runs an ioctl upload and
// stores the returned ioctl_din bytes into the buffer. A single FSM drives
// the protocol; one shared down-counter times the setup holds, the download
// gaps and the upload address holds. All outputs come straight from flops.
module hs_ioctl_player
  import hs_pkg::*;
#(
  parameter int BUF_AW       = 8,
  parameter int SETUP_CYCLES = 4,
  parameter int WR_GAP       = 3,
  parameter int UP_GAP       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_download,
  input  logic              start_upload,
  input  logic [7:0]        index,
  input  logic [24:0]       length,
  output logic [BUF_AW-1:0] buf_addr,
  input  logic [7:0]        buf_rdata,
  output logic [7:0]        buf_wdata,
  output logic              buf_we,
  output logic              busy,
  output logic              done,
  output logic              ioctl_download,
  output logic              ioctl_upload,
  output logic              ioctl_wr,
  output logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic [7:0]        ioctl_din
);

  // Largest transfer the buffer can source or sink.
  localparam logic [24:0] MAX_LEN = 25'(2**BUF_AW);

  // Counter reload values: the counter runs N-1 .. 0, giving N cycles.
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] GAP_LD   = 16'((WR_GAP > 0) ? (WR_GAP - 1) : 0);
  localparam logic [15:0] HOLD_LD  = 16'(UP_GAP - 1);

  // Current state registers.
  hs_state_e         r_state;
  logic [15:0]       r_cnt;
  logic [24:0]       r_len;
  logic              r_is_dl;
  logic [7:0]        r_index;
  logic [24:0]       r_addr;
  logic [7:0]        r_dout;
  logic              r_wr;
  logic              r_dl;
  logic              r_ul;
  logic              r_busy;
  logic              r_done;
  logic [BUF_AW-1:0] r_buf_addr;
  logic [7:0]        r_buf_wdata;
  logic              r_buf_we;

  // Next-state values computed by the combinational process.
  hs_state_e         w_state;
  logic [15:0]       w_cnt;
  logic [24:0]       w_len;
  logic              w_is_dl;
  logic [7:0]        w_index;
  logic [24:0]       w_addr;
  logic [7:0]        w_dout;
  logic              w_wr;
  logic              w_dl;
  logic              w_ul;
  logic              w_busy;
  logic              w_done;
  logic [BUF_AW-1:0] w_buf_addr;
  logic [7:0]        w_buf_wdata;
  logic              w_buf_we;

  // Helper terms.
  logic              w_start;
  logic [24:0]       w_clamp;
  logic              w_last;
  logic [24:0]       w_addr_inc;

  assign w_start    = start_download | start_upload;
  assign w_clamp    = hs_clamp_len(length, MAX_LEN);
  assign w_last     = (r_addr == (r_len - 25'd1));
  assign w_addr_inc = r_addr + 25'd1;

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_is_dl     = r_is_dl;
    w_index     = r_index;
    w_addr      = r_addr;
    w_dout      = r_dout;
    w_wr        = 1'b0;
    w_dl        = r_dl;
    w_ul        = r_ul;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_buf_addr  = r_buf_addr;
    w_buf_wdata = r_buf_wdata;
    w_buf_we    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_clamp == 25'd0) begin
            // Empty transfer: report completion without touching the bus.
            w_done = 1'b1;
          end else begin
            w_state = PRE;
            w_cnt   = SETUP_LD;
            w_len   = w_clamp;
            w_is_dl = start_download;
            w_index = index;
            w_busy  = 1'b1;
          end
        end else begin
          w_state = IDLE;
        end
      end

      PRE: begin
        if (r_cnt == 16'd0) begin
          w_addr = 25'd0;
          if (r_is_dl) begin
            w_dl       = 1'b1;
            w_buf_addr = {BUF_AW{1'b0}};
            w_state    = DL_FETCH;
          end else begin
            w_ul    = 1'b1;
            w_cnt   = HOLD_LD;
            w_state = UL_HOLD;
          end
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end

      DL_FETCH: begin
        // buf_addr is already presented; buf_rdata is valid next cycle.
        w_state = DL_WR;
      end

      DL_WR: begin
        w_dout = buf_rdata;
        w_wr   = 1'b1;
        if (WR_GAP > 0) begin
          w_cnt   = GAP_LD;
          w_state = DL_GAP;
        end else if (w_last) begin
          w_dl    = 1'b0;
          w_cnt   = SETUP_LD;
          w_state = POST;
        end else begin
          w_addr     = w_addr_inc;
          w_buf_addr = w_addr_inc[BUF_AW-1:0];
          w_state    = DL_FETCH;
        end
      end

      DL_GAP: begin
        if (r_cnt != 16'd0) begin
          w_cnt = r_cnt - 16'd1;
        end else if (w_last) begin
          w_dl    = 1'b0;
          w_cnt   = SETUP_LD;
          w_state = POST;
        end else begin
          w_addr     = w_addr_inc;
          w_buf_addr = w_addr_inc[BUF_AW-1:0];
          w_state    = DL_FETCH;
        end
      end

      UL_HOLD: begin
        if (r_cnt == 16'd0) begin
          w_state = UL_CAP;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end

      UL_CAP: begin
        w_buf_wdata = ioctl_din;
        w_buf_addr  = r_addr[BUF_AW-1:0];
        w_buf_we    = 1'b1;
        if (w_last) begin
          w_ul    = 1'b0;
          w_cnt   = SETUP_LD;
          w_state = POST;
        end else begin
          w_addr  = w_addr_inc;
          w_cnt   = HOLD_LD;
          w_state = UL_HOLD;
        end
      end

      POST: begin
        // Mode is already low; the index stays up for the trailing hold.
        if (r_cnt == 16'd0) begin
          w_index = 8'd0;
          w_addr  = 25'd0;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end

      default: begin
        w_state = IDLE;
        w_dl    = 1'b0;
        w_ul    = 1'b0;
        w_busy  = 1'b0;
        w_index = 8'd0;
        w_addr  = 25'd0;
      end
    endcase
  end

  // State and output registers; reset clears every output at once, so a
  // reset mid-transfer drops the mode line without the trailing index hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 16'd0;
      r_len       <= 25'd0;
      r_is_dl     <= 1'b0;
      r_index     <= 8'd0;
      r_addr      <= 25'd0;
      r_dout      <= 8'd0;
      r_wr        <= 1'b0;
      r_dl        <= 1'b0;
      r_ul        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_buf_addr  <= {BUF_AW{1'b0}};
      r_buf_wdata <= 8'd0;
      r_buf_we    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_len       <= w_len;
      r_is_dl     <= w_is_dl;
      r_index     <= w_index;
      r_addr      <= w_addr;
      r_dout      <= w_dout;
      r_wr        <= w_wr;
      r_dl        <= w_dl;
      r_ul        <= w_ul;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_buf_addr  <= w_buf_addr;
      r_buf_wdata <= w_buf_wdata;
      r_buf_we    <= w_buf_we;
    end
  end

  assign buf_addr       = r_buf_addr;
  assign buf_wdata      = r_buf_wdata;
  assign buf_we         = r_buf_we;
  assign busy           = r_busy;
  assign done           = r_done;
  assign ioctl_download = r_dl;
  assign ioctl_upload   = r_ul;
  assign ioctl_wr       = r_wr;
  assign ioctl_addr     = r_addr;
  assign ioctl_dout     = r_dout;
  assign ioctl_index    = r_index;

endmodule

// File: tb/tb_hs_ioctl_player.sv
// Self-checking bench for hs_ioctl_player. A timeline model derives every
// output per cycle from the transfer parameters (start cycle, length, kind,
// index); a compare process checks the DUT each cycle, and the stimulus adds
// literal checks on counted events and captured buffer contents.
module tb_hs_ioctl_player;
  import hs_pkg::*;

  localparam int AW = 8;
  localparam int S  = 4;
  localparam int G  = 3;
  localparam int U  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_download;
  logic          start_upload;
  logic [7:0]    index;
  logic [24:0]   length;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_rdata;
  logic [7:0]    buf_wdata;
  logic          buf_we;
  logic          busy;
  logic          done;
  logic          ioctl_download;
  logic          ioctl_upload;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [7:0]    ioctl_index;
  logic [7:0]    ioctl_din;

  hs_ioctl_player #(
    .BUF_AW(AW), .SETUP_CYCLES(S), .WR_GAP(G), .UP_GAP(U)
  ) dut (
    .clk(clk), .reset(reset),
    .start_download(start_download), .start_upload(start_upload),
    .index(index), .length(length),
    .buf_addr(buf_addr), .buf_rdata(buf_rdata),
    .buf_wdata(buf_wdata), .buf_we(buf_we),
    .busy(busy), .done(done),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_din(ioctl_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer: download image (bench written) and upload capture (DUT written).
  logic [7:0] img [0:255];
  logic [7:0] cap [0:255];
  logic [7:0] resp_d1;
  logic       prev_dl = 1'b0;
  logic       cfg_flag = 1'b0;

  always @(posedge clk) begin
    buf_rdata <= img[buf_addr];
    if (buf_we) cap[buf_addr] <= buf_wdata;
    // Upload responder: din = 0xA0 + addr, two cycles after the address.
    resp_d1   <= 8'hA0 + ioctl_addr[7:0];
    ioctl_din <= resp_d1;
    // Hiscore-style responder: config seen when a download with index 3 ends.
    prev_dl   <= ioctl_download;
    if (prev_dl && !ioctl_download && ioctl_index == HS_CONFIGINDEX) cfg_flag <= 1'b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model description of the current transfer (written by stimulus only).
  logic       m_act = 1'b0;
  int         m_s   = 0;
  int         m_len = 0;
  logic       m_dl  = 1'b0;
  logic [7:0] m_idx = 8'd0;

  // Event statistics (written by the compare process only).
  int st_wr = 0, st_we = 0, st_done = 0, st_dl = 0, st_ul = 0, st_busy = 0, st_idx = 0;
  int st_last_addr = 0;

  // Compare the DUT against the timeline model for cycle c.
  task automatic model_check(input int c);
    int p, m0, b, d, bi;
    logic e_busy, e_done, e_dl, e_ul, e_wr, e_we;
    logic [7:0]  e_idx;
    logic [24:0] e_addr;
    e_busy = 1'b0; e_done = 1'b0; e_dl = 1'b0; e_ul = 1'b0; e_wr = 1'b0; e_we = 1'b0;
    e_idx = 8'd0; e_addr = 25'd0; bi = 0;
    if (m_act) begin
      p  = m_dl ? (2 + G) : (U + 1);
      m0 = m_s + S;
      b  = m_len * p;
      d  = (m_len == 0) ? m_s : (m0 + b + S);
      e_done = (c == d);
      if (m_len > 0 && c >= m_s && c < d) begin
        e_busy = 1'b1;
        e_idx  = m_idx;
      end
      if (m_len > 0 && c >= m0 && c < m0 + b) begin
        e_dl   = m_dl;
        e_ul   = !m_dl;
        e_addr = 25'((c - m0) / p);
      end else if (m_len > 0 && c >= m0 + b && c < d) begin
        e_addr = 25'(m_len - 1);
      end
      if (m_dl && m_len > 0 && (c - m0 - 2) >= 0 && ((c - m0 - 2) % p) == 0
          && ((c - m0 - 2) / p) < m_len) begin
        e_wr = 1'b1;
        bi   = (c - m0 - 2) / p;
      end
      if (!m_dl && m_len > 0 && (c - m0) > 0 && ((c - m0) % p) == 0
          && ((c - m0) / p) <= m_len) begin
        e_we = 1'b1;
        bi   = (c - m0) / p - 1;
      end
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("ioctl_download", ioctl_download, e_dl);
    chk("ioctl_upload", ioctl_upload, e_ul);
    chk("ioctl_wr", ioctl_wr, e_wr);
    chk("ioctl_index", ioctl_index, e_idx);
    chk("ioctl_addr", ioctl_addr, e_addr);
    chk("buf_we", buf_we, e_we);
    if (e_wr) chk("ioctl_dout", ioctl_dout, img[bi]);
    if (e_we) begin
      chk("buf_addr", buf_addr, bi);
      chk("buf_wdata", buf_wdata, 8'(8'hA0 + bi));
    end
  endtask

  // Per-cycle compare and event counting, one time unit after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_check(cyc);
      if (ioctl_wr) st_wr++;
      if (buf_we) st_we++;
      if (done) st_done++;
      if (ioctl_download) st_dl++;
      if (ioctl_upload) st_ul++;
      if (busy) st_busy++;
      if (busy && !ioctl_download && !ioctl_upload && ioctl_index != 8'd0) st_idx++;
      if (ioctl_download || ioctl_upload) st_last_addr = int'(ioctl_addr);
    end
  end

  int b_wr, b_we, b_done, b_dl, b_ul, b_busy, b_idx;

  task automatic snap();
    b_wr = st_wr; b_we = st_we; b_done = st_done; b_dl = st_dl;
    b_ul = st_ul; b_busy = st_busy; b_idx = st_idx;
  endtask

  task automatic start_xfer(input logic dl, input logic ul, input logic [7:0] idx,
                            input logic [24:0] len);
    start_download = dl;
    start_upload   = ul;
    index          = idx;
    length         = len;
    m_s   = cyc + 1;
    m_len = (len > 25'd256) ? 256 : int'(len);
    m_dl  = dl;
    m_idx = idx;
    m_act = 1'b1;
    @(negedge clk);
    start_download = 1'b0;
    start_upload   = 1'b0;
  endtask

  task automatic wait_end();
    int p, tgt;
    p   = m_dl ? (2 + G) : (U + 1);
    tgt = (m_len == 0) ? m_s : (m_s + S + m_len * p + S);
    while (cyc < tgt + 2) @(negedge clk);
  endtask

  initial begin
    int tgt;
    reset = 1'b1; start_download = 1'b0; start_upload = 1'b0;
    index = 8'd0; length = 25'd0;
    for (int i = 0; i < 256; i++) img[i] = 8'(i * 37 + 11);
    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h43; img[3] = 8'h0b;
    img[4] = 8'h0f; img[5] = 8'h10; img[6] = 8'h01; img[7] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_dout", ioctl_dout, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_index", ioctl_index, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Download of the config image, 16 bytes, index 3.
    snap();
    start_xfer(1'b1, 1'b0, HS_CONFIGINDEX, 25'd16);
    wait_end();
    chk("dl16_wr_count", st_wr - b_wr, 16);
    chk("dl16_mode_cycles", st_dl - b_dl, 80);
    chk("dl16_index_hold_cycles", st_idx - b_idx, 8);
    chk("dl16_done_count", st_done - b_done, 1);
    chk("dl16_last_addr", st_last_addr, 15);
    chk("dl16_byte2", img[2], 8'h43);
    chk("dl16_cfg_seen", cfg_flag, 1'b1);

    // Upload of 8 bytes, index 4; responder returns 0xA0 + addr.
    snap();
    start_xfer(1'b0, 1'b1, HS_DUMPINDEX, 25'd8);
    wait_end();
    for (int i = 0; i < 8; i++) chk("ul8_capture", cap[i], 8'hA0 + 8'(i));
    chk("ul8_we_count", st_we - b_we, 8);
    chk("ul8_wr_count", st_wr - b_wr, 0);
    chk("ul8_mode_cycles", st_ul - b_ul, 56);
    chk("ul8_done_count", st_done - b_done, 1);

    // Zero length: only a done pulse.
    snap();
    start_xfer(1'b1, 1'b0, 8'd3, 25'd0);
    wait_end();
    chk("len0_done_count", st_done - b_done, 1);
    chk("len0_busy_cycles", st_busy - b_busy, 0);
    chk("len0_mode_cycles", st_dl - b_dl, 0);

    // Both starts together (download wins), then an ignored upload request.
    snap();
    start_xfer(1'b1, 1'b1, 8'd3, 25'd4);
    repeat (10) @(negedge clk);
    start_upload = 1'b1; index = 8'd4; length = 25'd8;
    @(negedge clk);
    start_upload = 1'b0;
    wait_end();
    chk("both_done_count", st_done - b_done, 1);
    chk("both_ul_cycles", st_ul - b_ul, 0);
    chk("both_wr_count", st_wr - b_wr, 4);

    // Reset during byte 5 of a 16-byte download, then a clean download.
    snap();
    start_xfer(1'b1, 1'b0, 8'd3, 25'd16);
    tgt = m_s + S + 5 * (2 + G) + 2;
    while (cyc < tgt) @(negedge clk);
    chk("rst_mid_wr_count", st_wr - b_wr, 6);
    reset = 1'b1;
    m_act = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_dout", ioctl_dout, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_mode", ioctl_download, 1'b0);
    chk("rst_mid_done_count", st_done - b_done, 0);
    repeat (3) @(negedge clk);
    snap();
    start_xfer(1'b1, 1'b0, 8'd3, 25'd16);
    wait_end();
    chk("after_rst_done_count", st_done - b_done, 1);
    chk("after_rst_wr_count", st_wr - b_wr, 16);

    // Length above buffer size is clamped to 256 bytes.
    for (int i = 0; i < 256; i++) img[i] = 8'(i) ^ 8'h5A;
    snap();
    start_xfer(1'b1, 1'b0, 8'd3, 25'd300);
    wait_end();
    chk("clamp_wr_count", st_wr - b_wr, 256);
    chk("clamp_last_addr", st_last_addr, 255);
    chk("clamp_mode_cycles", st_dl - b_dl, 1280);
    chk("clamp_done_count", st_done - b_done, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_ioctl_player.md
Name: hs_ioctl_player

Overview:
- Initiator side of the HPS ioctl byte-stream used by the hiscore block.
- Replays a byte image from a local buffer as an ioctl download (config or dump), or runs an ioctl upload and captures the returned ioctl_din bytes into the buffer.
- Used on-core for self-test and autoload, and by the bench as the reference driver for hiscore-style responders.

Parameters:
- BUF_AW, 8, local image buffer address width; max transfer is 2**BUF_AW bytes.
- SETUP_CYCLES, 4, cycles the index is held stable before the mode rises and after it falls.
- WR_GAP, 3, idle cycles between successive download ioctl_wr strobes (min 0).
- UP_GAP, 6, cycles each upload address is held before ioctl_din is sampled (min 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start_download  in  1  one-cycle request: replay buffer as download
- start_upload  in  1  one-cycle request: run upload and capture into buffer
- index  in  8  ioctl_index for the transfer; sampled at start
- length  in  25  byte count; sampled at start
- buf_addr  out  BUF_AW  buffer address
- buf_rdata  in  8  buffer read data, 1-cycle registered latency
- buf_wdata  out  8  captured upload byte
- buf_we  out  1  buffer write strobe
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer
- ioctl_download  out  1  download mode
- ioctl_upload  out  1  upload mode
- ioctl_wr  out  1  byte strobe
- ioctl_addr  out  25  byte address
- ioctl_dout  out  8  download data
- ioctl_index  out  8  transfer index
- ioctl_din  in  8  upload data returned by responder

Behaviour:
- Reset: all outputs 0; state IDLE.
- Reset mid-transfer: outputs go to 0 on the next edge, including the mode line without the trailing index hold. No done pulse. The responder sees a falling mode edge and will treat the transfer as ended.
- Latch: at accept, index and the clamped length are latched.
  - Clamped length is min(length, 2**BUF_AW).
  - When start_download and start_upload are both high, download wins.
  - Starts are ignored while busy=1.
- length=0: busy stays 0, no mode assertion, done pulses the cycle after the start.
- IDLE -> PRE:
  - ioctl_index <= latched index; busy=1.
  - Wait SETUP_CYCLES.
  - Then raise ioctl_download or ioctl_upload; ioctl_addr=0.
- Download path (DL_FETCH -> DL_WR -> DL_GAP):
  - DL_FETCH: buf_addr <= ioctl_addr[BUF_AW-1:0]; wait 1 cycle for buf_rdata.
  - DL_WR: ioctl_dout <= buf_rdata; ioctl_wr=1 for exactly one cycle. ioctl_addr and ioctl_dout stay stable from this cycle until the next address change; responders may decode on addr without wr.
  - DL_GAP: WR_GAP idle cycles. Then either increment ioctl_addr and return to DL_FETCH, or go to POST after the last byte.
- Upload path (UL_HOLD -> UL_CAP):
  - UL_HOLD: hold ioctl_addr for UP_GAP cycles.
  - UL_CAP: sample ioctl_din. buf_wdata <= ioctl_din; buf_addr <= ioctl_addr[BUF_AW-1:0]; buf_we=1 for one cycle.
  - Then increment ioctl_addr, or go to POST after the last byte.
  - ioctl_wr stays 0 during upload.
- POST:
  - Drop the mode line first; ioctl_index is held for SETUP_CYCLES more.
  - Then ioctl_index <= 0, ioctl_addr <= 0, done=1 for one cycle, busy=0, back to IDLE.
- Addresses: ioctl_addr counts 0..len-1 with a 25-bit increment; no wrap inside a transfer.
- Exact cycle budgets, measured from the mode rising edge to the mode falling edge:
  - Download: len*(2+WR_GAP).
  - Upload: len*(UP_GAP+1).

Decomposition:
- Package hs_pkg:
  - State enum: IDLE, PRE, DL_FETCH, DL_WR, DL_GAP, UL_HOLD, UL_CAP, POST.
  - Index constants HS_CONFIGINDEX=3 and HS_DUMPINDEX=4, shared with the hiscore block.
- No sub-module needed; the single FSM plus a shared gap/hold down-counter is natural.

Test Plan:
- Download idx 3, len 16, buffer 00 00 43 0b 0f 10 01 00 ... -> 16 wr pulses at addr 0..15 with matching dout. Index 3 is stable SETUP_CYCLES before the mode rises and after it falls. done pulses once; the hiscore responder reports downloaded_config=1.
- Upload idx 4, len 8, responder ioctl_din = 0xA0 + addr with 2-cycle latency -> buffer[0..7] = A0..A7, 8 buf_we pulses, ioctl_wr never high.
- length=0 -> no mode assertion; done pulses the cycle after start; busy never 1.
- start_download and start_upload in the same cycle -> download runs. A start_upload issued while busy is ignored; exactly one done pulse.
- Reset asserted at byte 5 of a 16-byte download -> next cycle all ioctl outputs are 0 and busy=0. No done pulse. A new download then completes normally.
- length=300 with BUF_AW=8 -> exactly 256 bytes transferred, last ioctl_addr=255.
